// File: rtl/serial_adder_seq.sv
// Wide add/subtract computed one 16-bit slice per cycle, LSB slice first,
// with the inter-slice carry held in a register and valid/ready on both sides.
module serial_adder_seq #(
  parameter int unsigned NUM_SLICES = 4,
  localparam int unsigned DATA_W = 16 * NUM_SLICES
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic              sub,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] sum,
  output logic              c_out,
  output logic              ovf,
  output logic              busy
);

  localparam int unsigned CNT_W = (NUM_SLICES > 1) ? $clog2(NUM_SLICES) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(NUM_SLICES - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t              state;
  logic [CNT_W-1:0]    cnt;
  logic                carry;
  logic [DATA_W-1:0]   a_reg;
  logic [DATA_W-1:0]   b_reg;
  logic [DATA_W-1:0]   sum_r;
  logic                c_out_r;
  logic                ovf_r;
  logic                out_valid_r;

  logic [15:0]         slice_a;
  logic [15:0]         slice_b;
  logic [15:0]         slice_s;
  logic                slice_co;

  always_comb begin
    slice_a = a_reg[{cnt, 4'd0} +: 16];
    slice_b = b_reg[{cnt, 4'd0} +: 16];
    {slice_co, slice_s} = {1'b0, slice_a} + {1'b0, slice_b} + 17'(carry);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      carry       <= 1'b0;
      a_reg       <= '0;
      b_reg       <= '0;
      sum_r       <= '0;
      c_out_r     <= 1'b0;
      ovf_r       <= 1'b0;
      out_valid_r <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_reg <= a;
            b_reg <= sub ? ~b : b;
            carry <= sub;
            cnt   <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          sum_r[{cnt, 4'd0} +: 16] <= slice_s;
          carry <= slice_co;
          cnt   <= cnt + 1'b1;
          if (cnt == LAST) begin
            // Flags come from the final slice directly so they line up with out_valid.
            c_out_r     <= slice_co;
            ovf_r       <= (a_reg[DATA_W-1] == b_reg[DATA_W-1]) &&
                           (slice_s[15] != a_reg[DATA_W-1]);
            out_valid_r <= 1'b1;
            state       <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_r <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign busy      = (state != IDLE);
  assign out_valid = out_valid_r;
  assign sum       = sum_r;
  assign c_out     = c_out_r;
  assign ovf       = ovf_r;

endmodule

// File: tb/tb_serial_adder_seq.sv
// Self-checking bench for serial_adder_seq (NUM_SLICES=4): directed table,
// backpressure and async-reset sequences, then random ops against an arithmetic model.
module tb_serial_adder_seq;

  localparam int unsigned NS = 4;
  localparam int unsigned W  = 16 * NS;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         sub = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] sum;
  logic         c_out;
  logic         ovf;
  logic         busy;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  serial_adder_seq #(.NUM_SLICES(NS)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .sub(sub), .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .c_out(c_out), .ovf(ovf), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         s;
    logic [W-1:0] sum;
    logic         c;
    logic         o;
  } vec_t;

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  // Reference: plain wide arithmetic with signed-overflow decided from operand signs.
  function automatic void model(input logic [W-1:0] x, input logic [W-1:0] y, input logic s,
                                output logic [W-1:0] r, output logic c, output logic o);
    logic [W:0] t;
    if (s) begin
      r = x - y;
      c = (x >= y);
      o = (x[W-1] != y[W-1]) && (r[W-1] != x[W-1]);
    end else begin
      t = {1'b0, x} + {1'b0, y};
      r = t[W-1:0];
      c = t[W];
      o = (x[W-1] == y[W-1]) && (r[W-1] != x[W-1]);
    end
  endfunction

  // Issue one op, measure latency, check result, then drain it.
  task automatic do_op(input string nm, input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                       input logic ts, input logic [W-1:0] es, input logic ec, input logic eo);
    int unsigned waits;
    int unsigned edges;
    @(negedge clk);
    waits = 0;
    while (!in_ready && waits < 20) begin @(negedge clk); waits++; end
    a = ta; b = tb_v; sub = ts; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    a = {$urandom, $urandom}; b = {$urandom, $urandom}; sub = ~ts;
    edges = 0;
    do begin
      @(posedge clk); edges++; #1;
    end while (!out_valid && edges < 20);
    chk({nm, " latency"}, W'(edges - 1 + 1), W'(NS));
    chk({nm, " sum"}, sum, es);
    chk({nm, " c_out"}, W'(c_out), W'(ec));
    chk({nm, " ovf"}, W'(ovf), W'(eo));
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk({nm, " drain"}, W'({out_valid, in_ready, busy}), W'(3'b010));
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  vec_t vecs[7];

  initial begin
    logic [W-1:0] es, hs, ra, rb;
    logic         ec, eo, hc, ho, rs;
    int unsigned  edges;

    vecs[0] = '{64'd1, 64'd1, 1'b0, 64'd2, 1'b0, 1'b0};
    vecs[1] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 64'd0, 1'b1, 1'b0};
    vecs[2] = '{64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 64'h8000_0000_0000_0000, 1'b0, 1'b1};
    vecs[3] = '{64'h8000_0000_0000_0000, 64'd1, 1'b1, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1};
    vecs[4] = '{64'd5, 64'd7, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0};
    vecs[5] = '{64'd7, 64'd5, 1'b1, 64'd2, 1'b1, 1'b0};
    vecs[6] = '{64'd0, 64'd0, 1'b1, 64'd0, 1'b1, 1'b0};

    // Reset state, with in_valid asserted to show it is ignored.
    in_valid = 1'b1; a = 64'd9; b = 64'd9;
    #12;
    chk("reset out_valid", W'(out_valid), '0);
    chk("reset sum", sum, '0);
    chk("reset flags", W'({c_out, ovf, busy}), '0);
    chk("reset in_ready", W'(in_ready), W'(1));
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 7; i++)
      do_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].s,
            vecs[i].sum, vecs[i].c, vecs[i].o);

    // Backpressure: result held, no second accept while stalled.
    model(64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b0, es, ec, eo);
    model(64'd100, 64'd58, 1'b1, hs, hc, ho);
    @(negedge clk);
    a = 64'h1234_5678_9ABC_DEF0; b = 64'h0FED_CBA9_8765_4321; sub = 1'b0; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    a = 64'd100; b = 64'd58; sub = 1'b1;
    edges = 0;
    while (!out_valid && edges < 20) begin @(negedge clk); edges++; end
    for (int i = 0; i < 10; i++) begin
      chk($sformatf("bp%0d sum", i), sum, es);
      chk($sformatf("bp%0d ctl", i), W'({out_valid, in_ready, busy, c_out, ovf}),
          W'({3'b101, ec, eo}));
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp release", W'({out_valid, in_ready}), W'(2'b01));
    @(negedge clk);
    out_ready = 1'b0;
    @(posedge clk); #1;
    chk("bp next accept", W'({in_ready, busy}), W'(2'b01));
    @(negedge clk);
    in_valid = 1'b0;
    edges = 1;
    do begin
      @(posedge clk); edges++; #1;
    end while (!out_valid && edges < 20);
    chk("bp2 latency", W'(edges - 1), W'(NS));
    chk("bp2 sum", sum, hs);
    chk("bp2 flags", W'({c_out, ovf}), W'({hc, ho}));
    @(negedge clk); out_ready = 1'b1;
    @(negedge clk); out_ready = 1'b0;

    // Asynchronous reset two RUN edges into an operation.
    @(negedge clk);
    a = 64'hFFFF_0000_FFFF_0000; b = 64'h0001_0001_0001_0001; sub = 1'b0; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk); in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst out_valid", W'(out_valid), '0);
    chk("midrst sum", sum, '0);
    chk("midrst busy/in_ready", W'({busy, in_ready}), W'(2'b01));
    @(negedge clk);
    rst_n = 1'b1;
    do_op("post reset", 64'd3, 64'd4, 1'b0, 64'd7, 1'b0, 1'b0);

    // Random operations, biased toward the sign/carry boundaries.
    for (int i = 0; i < 40; i++) begin
      ra = {$urandom, $urandom};
      rb = {$urandom, $urandom};
      rs = 1'($urandom);
      case ($urandom_range(0, 3))
        0: ra[W-1 -: 16] = 16'h7FFF;
        1: rb = ~ra;
        2: rb = ra;
        default: ;
      endcase
      model(ra, rb, rs, es, ec, eo);
      do_op($sformatf("rnd%0d", i), ra, rb, rs, es, ec, eo);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
